mem_access_ctrl: RTL and testbench

//  Memory-stage load/store sequencer. Takes one load/store per instruction, checks alignment,

---
 rtl/mem_access_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: alignment check, dbus request/response handshake,
// pipeline stall generation and lane-aligned, sign/zero-extended load data.
module mem_access_ctrl #(
  parameter bit POSTED_STORES = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  // Handshake: dreq_valid rises on entry to REQ and every dreq_* field stays stable until the
  // cycle dresp_addr_ok is high (a flush never withdraws it); dresp_data_ok then completes the
  // oldest outstanding access, which is a posted store whenever one is pending.

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_rdata_q;
  logic [1:0]  size_q;
  logic [3:0]  strobe_q;
  logic        uns_q;
  logic        write_q;
  logic        dreq_valid_q;
  logic        resp_valid_q;
  logic        discard_q;
  logic        store_pend_q;

  logic        misaligned;
  logic        in_idle;
  logic        pend_block;
  logic        req_live;
  logic        accept;
  logic        kill;
  logic        data_ok_own;
  logic [3:0]  strobe_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_d;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign in_idle     = (state_q == S_IDLE);
  assign pend_block  = POSTED_STORES && store_pend_q;
  assign req_live    = in_idle && req_valid && !flush;
  assign accept      = req_live && !misaligned && !pend_block;
  assign kill        = discard_q || flush;
  // A pending posted store owns the first data_ok that comes back.
  assign data_ok_own = dresp_data_ok && !store_pend_q;

  assign stall        = (state_q == S_REQ) || (state_q == S_WAIT) ||
                        (req_live && (pend_block || !misaligned));
  assign exc_adel     = req_live && misaligned && !pend_block && !req_write;
  assign exc_ades     = req_live && misaligned && !pend_block && req_write;
  assign exc_badvaddr = req_addr;

  assign resp_valid  = resp_valid_q && !flush;
  assign resp_rdata  = resp_rdata_q;
  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = strobe_q;
  assign dreq_data   = wdata_q;

  always_comb begin
    strobe_d = 4'b1111;
    wdata_d  = req_wdata;
    case (req_size)
      2'd0: begin
        strobe_d = 4'b0001 << req_addr[1:0];
        wdata_d  = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        strobe_d = 4'b0011 << req_addr[1:0];
        wdata_d  = {2{req_wdata[15:0]}};
      end
      default: strobe_d = 4'b1111;
    endcase
    if (!req_write) strobe_d = 4'b0000;
  end

  assign lane_byte = dresp_data[{addr_q[1:0], 3'b000} +: 8];
  assign lane_half = dresp_data[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'd0:    rdata_d = {{24{!uns_q && lane_byte[7]}}, lane_byte};
      2'd1:    rdata_d = {{16{!uns_q && lane_half[15]}}, lane_half};
      default: rdata_d = dresp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      dreq_valid_q <= 1'b0;
      resp_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      store_pend_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (store_pend_q && dresp_data_ok) store_pend_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q       <= req_addr;
            size_q       <= req_size;
            uns_q        <= req_unsigned;
            write_q      <= req_write;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
            discard_q    <= 1'b0;
            dreq_valid_q <= 1'b1;
            state_q      <= S_REQ;
          end
        end

        S_REQ: begin
          if (flush) discard_q <= 1'b1;
          if (dresp_addr_ok) begin
            dreq_valid_q <= 1'b0;
            if (data_ok_own) begin
              if (!write_q && !kill) resp_rdata_q <= rdata_d;
              resp_valid_q <= !kill;
              discard_q    <= 1'b0;
              state_q      <= kill ? S_IDLE : S_DONE;
            end else if (POSTED_STORES && write_q && !kill) begin
              // Store retires now; its data_ok is collected later via store_pend.
              store_pend_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (flush) discard_q <= 1'b1;
          if (data_ok_own) begin
            if (!write_q && !kill) resp_rdata_q <= rdata_d;
            resp_valid_q <= !kill;
            discard_q    <= 1'b0;
            state_q      <= kill ? S_IDLE : S_DONE;
          end
        end

        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl (posted stores enabled): transaction-level timeline model,
// per-cycle output compare, and hand-computed pins for the headline cases.
module tb_mem_access_ctrl;

  localparam bit POSTED = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  always #5 clk = ~clk;

  mem_access_ctrl #(.POSTED_STORES(POSTED)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Per-cycle expectations, set by the driver just after each rising edge.
  logic        exp_stall, exp_dv, exp_resp, exp_resp_ld, exp_adel, exp_ades, exp_wr;
  logic [31:0] exp_baddr, exp_daddr, exp_ddata;
  logic [1:0]  exp_dsize;
  logic [3:0]  exp_strb;
  logic [31:0] exp_q[$];

  bit          pin_en = 1'b0;
  logic [31:0] pin_rd, pin_data;
  logic [3:0]  pin_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] bus, input logic [1:0] a,
                                         input logic [1:0] sz, input bit uns);
    int nb;
    logic [31:0] mask, v;
    nb   = 1 << sz;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = (bus >> (8 * a)) & mask;
    if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input bit wr, input logic [1:0] sz, input logic [1:0] a);
    int nb, s;
    nb = 1 << sz;
    s  = ((1 << nb) - 1) << a;
    return wr ? 4'(s) : 4'b0000;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [1:0] sz);
    int nb;
    logic [31:0] d;
    nb = 1 << sz;
    for (int i = 0; i < 4; i++) d[8 * i +: 8] = w[8 * (i % nb) +: 8];
    return d;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("resp_valid", 32'(resp_valid), 32'(exp_resp));
      chk("dreq_valid", 32'(dreq_valid), 32'(exp_dv));
      chk("exc_adel", 32'(exc_adel), 32'(exp_adel));
      chk("exc_ades", 32'(exc_ades), 32'(exp_ades));
      if (exp_adel || exp_ades) chk("badvaddr", exc_badvaddr, exp_baddr);
      if (exp_dv) begin
        chk("dreq_addr", dreq_addr, exp_daddr);
        chk("dreq_size", 32'(dreq_size), 32'(exp_dsize));
        chk("dreq_strobe", 32'(dreq_strobe), 32'(exp_strb));
        if (exp_wr) chk("dreq_data", dreq_data, exp_ddata);
      end
      if (exp_resp_ld) begin
        if (exp_q.size() == 0) chk("exp_q_underflow", 32'd1, 32'd0);
        else chk("resp_rdata", resp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                           input bit uns, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size = sz; req_unsigned = uns; req_wdata = wd;
  endtask

  task automatic bus(input bit aok, input bit dok, input logic [31:0] d);
    dresp_addr_ok = aok; dresp_data_ok = dok; dresp_data = d;
  endtask

  task automatic expect_cyc(input bit st, input bit dv, input bit rv, input bit rld);
    exp_stall = st; exp_dv = dv; exp_resp = rv; exp_resp_ld = rld;
    exp_adel = 1'b0; exp_ades = 1'b0;
  endtask

  // One aligned access: addr_ok after a_dly REQ cycles, data_ok d_dly cycles after addr_ok,
  // optional flush at cycle flush_at (relative to the accept cycle, -1 = none).
  task automatic access(input bit wr, input logic [31:0] addr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] wdata, input logic [31:0] rd_word,
                        input int a_dly, input int d_dly, input int flush_at);
    int last, done_c;
    bit disc, fl_done, killed;
    last    = 1 + a_dly + d_dly;
    done_c  = last + 1;
    disc    = (flush_at >= 1) && (flush_at <= last);
    fl_done = (flush_at == done_c);
    if (!wr && !disc && !fl_done)
      exp_q.push_back(pin_en ? pin_rd : m_load(rd_word, addr[1:0], sz, uns));
    exp_wr    = wr;
    exp_daddr = addr;
    exp_dsize = sz;
    exp_strb  = (pin_en && wr) ? pin_strb : m_strb(wr, sz, addr[1:0]);
    exp_ddata = (pin_en && wr) ? pin_data : m_wdata(wdata, sz);
    for (int c = 0; c <= done_c; c++) begin
      killed = (flush_at >= 0) && (c >= flush_at);
      drive_req(wr, addr, sz, uns, wdata);
      req_valid = !killed;
      flush     = (c == flush_at);
      bus(c == 1 + a_dly, c == last, (c == last) ? rd_word : 32'h5A5A_0000 + 32'(c));
      expect_cyc(c <= last, (c >= 1) && (c <= 1 + a_dly),
                 (c == done_c) && !disc && !fl_done,
                 (c == done_c) && !disc && !fl_done && !wr);
      tick();
    end
    req_valid = 1'b0; flush = 1'b0;
    bus(1'b0, 1'b0, 32'h0);
  endtask

  task automatic bad_access(input bit wr, input logic [31:0] addr, input logic [1:0] sz);
    drive_req(wr, addr, sz, 1'b0, 32'h1357_9BDF);
    flush = 1'b0;
    bus(1'b0, 1'b0, 32'h0);
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_adel = !wr; exp_ades = wr; exp_baddr = addr;
    tick();
    req_valid = 1'b0;
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  logic [31:0] t_addr[8] = '{32'h7000, 32'h7001, 32'h7002, 32'h7000,
                             32'h7002, 32'h7000, 32'h7000, 32'h7003};
  logic [1:0]  t_size[8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
  bit          t_uns[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t_bus[8]  = '{32'h1234_567F, 32'h1234_F67F, 32'h12AB_5678, 32'h1234_ABCD,
                             32'h7FFF_0000, 32'h0000_FFFE, 32'h89AB_CDEF, 32'hFF00_0000};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive_req(1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    req_valid = 1'b0;
    bus(1'b0, 1'b0, 32'h0);
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_wr = 1'b0; exp_baddr = '0; exp_daddr = '0; exp_ddata = '0; exp_dsize = '0; exp_strb = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    chk("rst_exc", 32'({exc_adel, exc_ades}), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_dreq_addr", dreq_addr, 32'd0);
    chk("rst_dreq_strobe", 32'(dreq_strobe), 32'd0);
    chk("rst_dreq_data", dreq_data, 32'd0);
    tick();
    chk_en = 1'b1;

    // Signed byte from lane 3, addr_ok and data_ok together.
    pin_en = 1'b1; pin_rd = 32'hFFFF_FF80;
    access(1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'h0, 32'h80AB_CD12, 0, 0, -1);
    // Unsigned half from upper lane, data_ok 4 cycles after addr_ok.
    pin_rd = 32'h0000_9234;
    access(1'b0, 32'h0000_2002, 2'd1, 1'b1, 32'h0, 32'h9234_5678, 0, 4, -1);
    // Store half to upper lane.
    pin_strb = 4'b1100; pin_data = 32'hBEEF_BEEF;
    access(1'b1, 32'h0000_3002, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0, 0, 0, -1);
    pin_en = 1'b0;

    bad_access(1'b0, 32'h0000_4001, 2'd2);
    bad_access(1'b1, 32'h0000_4002, 2'd2);
    bad_access(1'b0, 32'h0000_4003, 2'd1);
    bad_access(1'b1, 32'h0000_4001, 2'd1);
    bad_access(1'b0, 32'h0000_4000, 2'd3);

    // addr_ok withheld 10 cycles: request fields checked stable every REQ cycle.
    access(1'b1, 32'h0000_6001, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 10, 0, -1);
    access(1'b1, 32'h0000_6000, 2'd1, 1'b0, 32'hCAFE_1234, 32'h0, 2, 0, -1);
    access(1'b1, 32'h0000_6004, 2'd2, 1'b0, 32'h0BAD_F00D, 32'h0, 1, 0, -1);

    for (int i = 0; i < 8; i++)
      access(1'b0, t_addr[i], t_size[i], t_uns[i], 32'h0, t_bus[i], i % 3, (i * 2) % 5, -1);

    // Flush in WAIT, in REQ (request held to addr_ok), and in DONE.
    access(1'b0, 32'h0000_5000, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 1, 3, 3);
    access(1'b0, 32'h0000_5004, 2'd2, 1'b0, 32'h0, 32'h3333_4444, 3, 0, 1);
    access(1'b0, 32'h0000_5008, 2'd0, 1'b0, 32'h0, 32'h0000_0080, 0, 1, 3);
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Posted SW then LW: SW retires at addr_ok, LW waits for SW's data_ok 5 cycles later.
    exp_wr = 1'b1; exp_daddr = 32'h100; exp_dsize = 2'd2; exp_strb = 4'hF; exp_ddata = 32'h1122_3344;
    drive_req(1'b1, 32'h100, 2'd2, 1'b0, 32'h1122_3344);
    bus(1'b0, 1'b0, 32'h0); expect_cyc(1'b1, 1'b0, 1'b0, 1'b0); tick();
    bus(1'b1, 1'b0, 32'h0); expect_cyc(1'b1, 1'b1, 1'b0, 1'b0); tick();
    bus(1'b0, 1'b0, 32'h0); expect_cyc(1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive_req(1'b0, 32'h104, 2'd2, 1'b0, 32'h0);
    exp_q.push_back(32'hCAFE_F00D);
    for (int c = 3; c <= 7; c++) begin
      bus(1'b0, c == 6, 32'h7777_0000);
      expect_cyc(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    exp_wr = 1'b0; exp_daddr = 32'h104; exp_strb = 4'h0;
    bus(1'b1, 1'b1, 32'hCAFE_F00D); expect_cyc(1'b1, 1'b1, 1'b0, 1'b0); tick();
    bus(1'b0, 1'b0, 32'h0); expect_cyc(1'b0, 1'b0, 1'b1, 1'b1); tick();
    req_valid = 1'b0;

    // Reset while in WAIT abandons the load.
    exp_daddr = 32'h9000;
    drive_req(1'b0, 32'h9000, 2'd2, 1'b0, 32'h0);
    bus(1'b0, 1'b0, 32'h0); expect_cyc(1'b1, 1'b0, 1'b0, 1'b0); tick();
    bus(1'b1, 1'b0, 32'h0); expect_cyc(1'b1, 1'b1, 1'b0, 1'b0); tick();
    bus(1'b0, 1'b0, 32'h0); expect_cyc(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk_en = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; req_valid = 1'b0; chk_en = 1'b1;
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
    chk("mid_rst_dreq_addr", dreq_addr, 32'd0);
    tick();
    bus(1'b0, 1'b1, 32'hFFFF_FFFF); tick();
    bus(1'b0, 1'b0, 32'h0);

    pin_en = 1'b1; pin_rd = 32'hDEAD_BEEF;
    access(1'b0, 32'h0000_8000, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1, 2, -1);
    pin_en = 1'b0;
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk_en = 1'b0;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
